frame_sync_ctrl: RTL and testbench
==================================

FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

Interface
REQ-001 The block SHALL have parameter PAYLOAD_W, default 8: payload bits captured per frame.
REQ-002 The block SHALL have parameter SYNC_PAT, default 4'b1011: sync pattern, MSB received first.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1: high to run; low to force IDLE.
REQ-006 The block SHALL have port in, input, 1: serial data bit, sampled every rising edge.
REQ-007 The block SHALL have port payload, output, PAYLOAD_W: captured payload, MSB first on the wire.
REQ-008 The block SHALL have port payload_valid, output, 1: payload holds an unconsumed frame.
REQ-009 The block SHALL have port payload_ready, input, 1: consumer accepts when valid&&ready at an edge.
REQ-010 The block SHALL have port overrun, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-011 The block SHALL have port parity_err, output, 1: one-cycle pulse on parity failure (see Configuration).
REQ-012 The block SHALL have port frame_count, output, 8: accepted-frame counter.

Function
REQ-013 The FSM SHALL have states IDLE, HUNT, CAPTURE and, with the macro defined only, PARITY.
REQ-014 IDLE->HUNT SHALL occur at the first edge with enable=1; the sync shift register SHALL be cleared to 0 on that transition.
REQ-015 In HUNT, sync SHALL be detected at an edge where {shift[2:0],in}==SYNC_PAT; overlapping patterns SHALL be detected.
REQ-016 The FSM SHALL move to CAPTURE on the edge following detection, with the bit counter at 0.
REQ-017 CAPTURE SHALL shift in into a capture register MSB-first for exactly PAYLOAD_W edges.
REQ-018 After the last payload bit, the FSM SHALL go to HUNT, or to PARITY if the macro is defined, with the shift register cleared; bits received during CAPTURE SHALL NOT contribute to sync detection.
REQ-019 On frame completion, payload_valid SHALL assert on the edge after the last payload bit is sampled (latency 1 edge).
REQ-020 The output buffer SHALL be one entry; payload SHALL stay stable while valid=1.
REQ-021 valid&&ready at an edge with no completion SHALL clear valid at that edge.
REQ-022 Completion with valid=0, or with valid&&ready at the same edge, SHALL load the new frame and keep valid=1.
REQ-023 Completion with valid=1 and ready=0 SHALL drop the new frame, keep the old payload, and pulse overrun for 1 cycle.
REQ-024 frame_count SHALL increment on each frame loaded into the buffer, wrapping 255->0; dropped and parity-failed frames SHALL NOT increment it.
REQ-025 enable=0 in any state SHALL force IDLE at the next edge and discard any partial frame without overrun or parity_err; the output buffer, valid and frame_count SHALL be retained.
REQ-026 overrun and parity_err SHALL be single-cycle pulses and otherwise 0.

Reset
REQ-027 Reset SHALL be synchronous active-high and SHALL take priority over enable.
REQ-028 Reset SHALL set: state=IDLE, shift=0, bit counter=0, payload=0, payload_valid=0, overrun=0, parity_err=0, frame_count=0.
REQ-029 Reset mid-CAPTURE SHALL discard the partial frame with no pulse outputs.

Configuration
REQ-030 Macro FRAME_PARITY_EN, when defined, SHALL add state PARITY, which samples one extra bit after the payload.
REQ-031 With FRAME_PARITY_EN, the frame SHALL be accepted (per REQ-019..024, latency measured from the parity bit) only if the XOR of the payload and parity bit is 0 (even parity); otherwise the frame SHALL be discarded and parity_err pulsed for 1 cycle, with the next state HUNT either way.
REQ-032 Without FRAME_PARITY_EN, there SHALL be no PARITY state, frame length SHALL be 4+PAYLOAD_W bits, and parity_err SHALL be tied 0.

Verification
REQ-033 Reset then enable=1, ready=0, stream 1011 then 10100101 -> payload=8'hA5, valid=1 one edge after the last bit, frame_count=1.
REQ-034 Stream 1011011 then payload 8'h3C -> overlapping sync found at the 4th bit; payload=8'h3C.
REQ-035 Hold ready=0 and send two back-to-back frames 8'h11 then 8'h22 -> payload stays 8'h11, overrun pulses once, frame_count=1.
REQ-036 Assert ready on the same edge that frame 8'h22 completes while 8'h11 is valid -> payload=8'h22, valid stays 1, no overrun.
REQ-037 Drop enable after 3 payload bits, then re-enable -> no valid, count unchanged, and the next full frame is captured correctly.
REQ-038 With FRAME_PARITY_EN, send frame 8'h01 with parity bit 0 -> parity_err pulse, no valid; send it with parity bit 1 -> accepted.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: hunts a 4-bit serial sync pattern, captures PAYLOAD_W bits MSB-first and
// hands them to a consumer through a one-entry buffer. Define FRAME_PARITY_EN to add an even-parity bit.
module frame_sync_ctrl #(
  parameter int         PAYLOAD_W = 8,
  parameter logic [3:0] SYNC_PAT  = 4'b1011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 payload_valid,
  input  logic                 payload_ready,
  output logic                 overrun,
  output logic                 parity_err,
  output logic [7:0]           frame_count
);

  // state   | meaning
  // IDLE    | disabled; leaves on the first enabled edge with the sync history cleared
  // HUNT    | shifting serial bits, looking for SYNC_PAT (overlaps allowed)
  // CAPTURE | shifting PAYLOAD_W payload bits MSB-first
  // PARITY  | sampling the even-parity bit (FRAME_PARITY_EN builds only)
`ifdef FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, HUNT, CAPTURE, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, HUNT, CAPTURE} state_t;
`endif

  localparam int                CNT_W    = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PAYLOAD_W - 1);

  state_t                 state;
  logic [2:0]             shift;
  logic [CNT_W-1:0]       cnt;
  logic [PAYLOAD_W-1:0]   cap;
  logic                   done;
  logic [3:0]             sync_win;
  logic                   sync_hit;
  logic [PAYLOAD_W-1:0]   cap_next;

  assign sync_win = {shift, in};
  assign sync_hit = (sync_win == SYNC_PAT);
  assign cap_next = {cap[PAYLOAD_W-2:0], in};

`ifdef FRAME_PARITY_EN
  logic bad;
`endif

  // done is a one-edge strobe telling the buffer that cap holds a complete, good frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
      cap   <= '0;
      done  <= 1'b0;
`ifdef FRAME_PARITY_EN
      bad   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef FRAME_PARITY_EN
      bad  <= 1'b0;
`endif
      if (!enable) begin
        state <= IDLE;
        shift <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= HUNT;
            shift <= '0;
          end
          HUNT: begin
            shift <= sync_win[2:0];
            if (sync_hit) begin
              state <= CAPTURE;
              cnt   <= '0;
            end
          end
          CAPTURE: begin
            cap <= cap_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              shift <= '0;
`ifdef FRAME_PARITY_EN
              state <= PARITY;
`else
              state <= HUNT;
              done  <= 1'b1;
`endif
            end
          end
`ifdef FRAME_PARITY_EN
          PARITY: begin
            state <= HUNT;
            shift <= '0;
            if (^{cap, in})
              bad  <= 1'b1;
            else
              done <= 1'b1;
          end
`endif
          default: begin
            state <= IDLE;
            shift <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // One-entry output buffer; a completed frame arriving while the buffer is full and not
  // being drained is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      payload       <= '0;
      payload_valid <= 1'b0;
      overrun       <= 1'b0;
      frame_count   <= '0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!payload_valid || payload_ready) begin
          payload       <= cap;
          payload_valid <= 1'b1;
          frame_count   <= frame_count + 8'd1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (payload_valid && payload_ready) begin
        payload_valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)
      parity_err <= 1'b0;
    else
      parity_err <= bad;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: vector table plus directed multi-cycle sequences, with a
// scoreboard that checks every frame loaded into the output buffer.
module tb_frame_sync_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       din;
  logic [7:0] payload;
  logic       payload_valid;
  logic       payload_ready;
  logic       overrun;
  logic       parity_err;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt;
  logic [7:0] prev_cnt;

  typedef struct {
    logic [7:0] pre;
    int         pre_len;
    logic [7:0] data;
    logic [7:0] exp_payload;
  } vec_t;
  vec_t vecs[6];

  frame_sync_ctrl #(.PAYLOAD_W(8), .SYNC_PAT(4'b1011)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in(din),
    .payload(payload), .payload_valid(payload_valid), .payload_ready(payload_ready),
    .overrun(overrun), .parity_err(parity_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bit_edge(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_edge(v[i]);
  endtask

  // payload bits (plus the even-parity bit when enabled); the frame is expected to be loaded
  task automatic send_payload(input logic [7:0] d);
    exp_q.push_back(d);
    send_bits({8'h00, d}, 8);
`ifdef FRAME_PARITY_EN
    bit_edge(^d);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(16'h000b, 4);
    send_payload(d);
  endtask

  task automatic consume();
    payload_ready = 1'b1;
    bit_edge(1'b0);
    payload_ready = 1'b0;
    check("consume_clears_valid", payload_valid, 0);
  endtask

  // scoreboard: every increment of frame_count is one loaded frame
  initial begin
    prev_cnt = 8'h00;
    forever begin
      @(negedge clk);
      if (frame_count == 8'(prev_cnt + 8'd1)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_load", frame_count, prev_cnt);
        end else begin
          check("sb_payload", payload, exp_q.pop_front());
          check("sb_valid", payload_valid, 1);
        end
      end
      prev_cnt = frame_count;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pre: 8'h00, pre_len: 0, data: 8'hA5, exp_payload: 8'hA5};
    vecs[1] = '{pre: 8'h02, pre_len: 2, data: 8'h3C, exp_payload: 8'h3C};
    vecs[2] = '{pre: 8'h06, pre_len: 3, data: 8'h00, exp_payload: 8'h00};
    vecs[3] = '{pre: 8'h07, pre_len: 3, data: 8'hFF, exp_payload: 8'hFF};
    vecs[4] = '{pre: 8'h01, pre_len: 2, data: 8'h80, exp_payload: 8'h80};
    vecs[5] = '{pre: 8'h00, pre_len: 0, data: 8'h01, exp_payload: 8'h01};

    reset = 1'b1; enable = 1'b1; din = 1'b0; payload_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", payload_valid, 0);
    check("rst_payload", payload, 0);
    check("rst_count", frame_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    reset = 1'b0;
    exp_cnt = 8'h00;

    bit_edge(1'b0);  // IDLE -> HUNT
    for (int v = 0; v < 6; v++) begin
      send_bits({8'h00, vecs[v].pre}, vecs[v].pre_len);
      send_frame(vecs[v].data);
      check("lat_not_yet_valid", payload_valid, 0);
      bit_edge(1'b0);
      exp_cnt = exp_cnt + 8'd1;
      check("vec_valid", payload_valid, 1);
      check("vec_payload", payload, vecs[v].exp_payload);
      check("vec_count", frame_count, exp_cnt);
      check("vec_overrun", overrun, 0);
      check("vec_parity_err", parity_err, 0);
      consume();
    end

    // overlapping sync from IDLE: the first bit lands on the IDLE->HUNT edge, so the
    // detected pattern is the one starting at the 4th bit
    enable = 1'b0;
    bit_edge(1'b0);
    enable = 1'b1;
    send_bits(16'h005b, 7);
    send_payload(8'h3C);
    bit_edge(1'b0);
    exp_cnt = exp_cnt + 8'd1;
    check("ovl_payload", payload, 8'h3C);
    check("ovl_valid", payload_valid, 1);
    consume();

    // back-to-back frames, ready low: second frame dropped
    send_frame(8'h11);
    bit_edge(1'b0);
    exp_cnt = exp_cnt + 8'd1;
    send_bits(16'h000b, 4);
    send_bits(16'h0022, 8);
`ifdef FRAME_PARITY_EN
    bit_edge(1'b0);
`endif
    bit_edge(1'b0);
    check("ovr_pulse", overrun, 1);
    check("ovr_payload_kept", payload, 8'h11);
    check("ovr_count", frame_count, exp_cnt);
    bit_edge(1'b0);
    check("ovr_single_cycle", overrun, 0);
    check("ovr_still_valid", payload_valid, 1);
    consume();

    // drain on the same edge a new frame completes
    send_frame(8'h11);
    bit_edge(1'b0);
    exp_cnt = exp_cnt + 8'd1;
    send_frame(8'h22);
    payload_ready = 1'b1;
    bit_edge(1'b0);
    payload_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("same_edge_payload", payload, 8'h22);
    check("same_edge_valid", payload_valid, 1);
    check("same_edge_no_overrun", overrun, 0);
    check("same_edge_count", frame_count, exp_cnt);
    consume();

    // disable mid-capture
    send_bits(16'h000b, 4);
    send_bits(16'h0005, 3);
    enable = 1'b0;
    bit_edge(1'b0);
    bit_edge(1'b1);
    check("dis_no_valid", payload_valid, 0);
    check("dis_count", frame_count, exp_cnt);
    check("dis_no_overrun", overrun, 0);
    enable = 1'b1;
    bit_edge(1'b0);
    send_frame(8'h5A);
    bit_edge(1'b0);
    exp_cnt = exp_cnt + 8'd1;
    check("dis_next_payload", payload, 8'h5A);
    check("dis_next_count", frame_count, exp_cnt);
    consume();

`ifdef FRAME_PARITY_EN
    send_bits(16'h000b, 4);
    send_bits(16'h0001, 8);
    bit_edge(1'b0);
    bit_edge(1'b0);
    check("par_err_pulse", parity_err, 1);
    check("par_err_no_valid", payload_valid, 0);
    check("par_err_count", frame_count, exp_cnt);
    bit_edge(1'b0);
    check("par_err_single_cycle", parity_err, 0);
    send_frame(8'h01);
    bit_edge(1'b0);
    exp_cnt = exp_cnt + 8'd1;
    check("par_ok_payload", payload, 8'h01);
    check("par_ok_valid", payload_valid, 1);
    check("par_ok_no_err", parity_err, 0);
    consume();
`endif

    // reset mid-capture
    send_bits(16'h000b, 4);
    send_bits(16'h000f, 4);
    reset = 1'b1;
    bit_edge(1'b1);
    reset = 1'b0;
    check("rstcap_valid", payload_valid, 0);
    check("rstcap_count", frame_count, 0);
    check("rstcap_overrun", overrun, 0);
    check("rstcap_parity_err", parity_err, 0);
    bit_edge(1'b0);
    bit_edge(1'b0);
    check("rstcap_quiet_overrun", overrun, 0);
    check("rstcap_quiet_parity", parity_err, 0);

    // 256 frames with ready held high: counter wraps to 0
    payload_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i));
      bit_edge(1'b0);
    end
    check("wrap_count", frame_count, 0);
    send_frame(8'hC3);
    bit_edge(1'b0);
    check("wrap_next_count", frame_count, 1);
    check("wrap_next_payload", payload, 8'hC3);
    bit_edge(1'b0);
    check("ready_clears_valid", payload_valid, 0);
    payload_ready = 1'b0;

    bit_edge(1'b0);
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
